// File: rtl/swd_pkg.sv
// swd_pkg: shared SWD ACK codes, frame bit positions and sequencer states
package swd_pkg;
   typedef enum logic [2:0] {
      ACK_OK    = 3'b001,
      ACK_WAIT  = 3'b010,
      ACK_FAULT = 3'b100
   } ack_t;
   localparam int REQ_LO    = 2;
   localparam int TURN1     = 10;
   localparam int ACK_LO    = TURN1 + 1;
   localparam int RDATA_LO  = 14;
   localparam int WDATA_LO  = 15;
   localparam int PAR_R     = 46;
   localparam int PAR_W     = 47;
   localparam int FRAME_LEN = 48;
   typedef enum logic [1:0] {ST_GAP, ST_IDLE, ST_ARM, ST_SHIFT} state_t;
endpackage

// File: rtl/swd_frame_sequencer_if.sv
// swd_frame_sequencer_if: command, response and frontend serial signals of the sequencer
interface swd_frame_sequencer_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_apndp;
   logic        cmd_rnw;
   logic [1:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic [2:0]  rsp_ack;
   logic [31:0] rsp_rdata;
   logic        rsp_par_err;
   logic        rsp_aborted;
   logic        fe_rst_n;
   logic        fe_rnw;
   logic        mosi;
   logic        miso;
   modport master (
      output cmd_valid, cmd_apndp, cmd_rnw, cmd_addr, cmd_wdata, miso,
      input  cmd_ready, rsp_valid, rsp_ack, rsp_rdata, rsp_par_err, rsp_aborted,
             fe_rst_n, fe_rnw, mosi
   );
   modport slave (
      input  cmd_valid, cmd_apndp, cmd_rnw, cmd_addr, cmd_wdata, miso,
      output cmd_ready, rsp_valid, rsp_ack, rsp_rdata, rsp_par_err, rsp_aborted,
             fe_rst_n, fe_rnw, mosi
   );
endinterface

// File: rtl/swd_req_builder.sv
// swd_req_builder: SWD request byte (start, APnDP, RnW, A[3:2], parity, stop, park), LSB sent first
module swd_req_builder (
   input  logic       apndp,
   input  logic       rnw,
   input  logic [1:0] addr,
   output logic [7:0] req
);
   logic par;
   assign par = apndp ^ rnw ^ addr[0] ^ addr[1];
   assign req = {1'b1, 1'b0, par, addr[1], addr[0], rnw, apndp, 1'b1};
endmodule

// File: rtl/swd_frame_sequencer.sv
// swd_frame_sequencer: accepts one SWD command, streams its 48-bit frame to the frontend and returns the response
module swd_frame_sequencer
   import swd_pkg::*;
#(
   parameter int IDLE_GAP      = 1,
   parameter bit ABORT_ON_NACK = 1'b1
) (
   input logic                  sck,
   input logic                  rst_n,
   swd_frame_sequencer_if.slave bus
);
   localparam int GW = $clog2(IDLE_GAP + 1);
   localparam int CW = $clog2(FRAME_LEN);
   state_t               state;
   logic [GW-1:0]        gap_cnt;
   logic [CW-1:0]        bit_cnt;
   logic [FRAME_LEN-1:0] frame;
   logic [FRAME_LEN-1:0] frame_new;
   logic [2:0]           ack_sh;
   logic [2:0]           ack_now;
   logic [31:0]          rdata_sh;
   logic                 rpar;
   logic [7:0]           req;
   logic                 in_ack;
   logic                 in_rdata;
   logic                 nack_stop;
   swd_req_builder u_req (
      .apndp(bus.cmd_apndp),
      .rnw  (bus.cmd_rnw),
      .addr (bus.cmd_addr),
      .req  (req)
   );
   // whole host frame is prebuilt at accept and shifted out LSB first
   assign frame_new = (FRAME_LEN'(req) << REQ_LO)
                    | (bus.cmd_rnw ? '0 : (FRAME_LEN'(bus.cmd_wdata) << WDATA_LO)
                                        | (FRAME_LEN'(^bus.cmd_wdata) << PAR_W));
   assign ack_now   = {bus.miso, ack_sh[2:1]};
   assign in_ack    = bit_cnt >= CW'(ACK_LO) && bit_cnt <= CW'(ACK_LO + 2);
   assign in_rdata  = bit_cnt >= CW'(RDATA_LO) && bit_cnt < CW'(RDATA_LO + 32);
   assign nack_stop = ABORT_ON_NACK && bit_cnt == CW'(ACK_LO + 2) && ack_now != ACK_OK;
   always_ff @(posedge sck or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_GAP;
         gap_cnt         <= GW'(IDLE_GAP);
         bit_cnt         <= '0;
         frame           <= '0;
         ack_sh          <= '0;
         rdata_sh        <= '0;
         rpar            <= 1'b0;
         bus.cmd_ready   <= 1'b0;
         bus.rsp_valid   <= 1'b0;
         bus.rsp_ack     <= '0;
         bus.rsp_rdata   <= '0;
         bus.rsp_par_err <= 1'b0;
         bus.rsp_aborted <= 1'b0;
         bus.fe_rst_n    <= 1'b0;
         bus.fe_rnw      <= 1'b0;
         bus.mosi        <= 1'b0;
      end else begin
         bus.rsp_valid <= 1'b0;
         case (state)
            ST_GAP: begin
               if (gap_cnt == GW'(1)) begin
                  state         <= ST_IDLE;
                  bus.cmd_ready <= 1'b1;
               end else begin
                  gap_cnt <= gap_cnt - GW'(1);
               end
            end
            ST_IDLE: begin
               if (bus.cmd_valid) begin
                  state         <= ST_ARM;
                  bus.cmd_ready <= 1'b0;
                  bus.fe_rnw    <= bus.cmd_rnw;
                  frame         <= frame_new;
               end
            end
            ST_ARM: begin
               state        <= ST_SHIFT;
               bus.fe_rst_n <= 1'b1;
               bus.mosi     <= frame[0];
               frame        <= frame >> 1;
               bit_cnt      <= '0;
            end
            ST_SHIFT: begin
               bus.mosi <= frame[0];
               frame    <= frame >> 1;
               bit_cnt  <= bit_cnt + CW'(1);
               if (in_ack) ack_sh <= ack_now;
               if (bus.fe_rnw && in_rdata) rdata_sh <= {bus.miso, rdata_sh[31:1]};
               if (bit_cnt == CW'(PAR_R)) rpar <= bus.miso;
               if (nack_stop || bit_cnt == CW'(FRAME_LEN - 1)) begin
                  state           <= ST_GAP;
                  gap_cnt         <= GW'(IDLE_GAP);
                  bus.fe_rst_n    <= 1'b0;
                  bus.mosi        <= 1'b0;
                  bus.rsp_valid   <= 1'b1;
                  bus.rsp_ack     <= nack_stop ? ack_now : ack_sh;
                  bus.rsp_aborted <= nack_stop;
                  bus.rsp_rdata   <= (bus.fe_rnw && !nack_stop) ? rdata_sh : '0;
                  bus.rsp_par_err <= bus.fe_rnw && !nack_stop && (rpar != ^rdata_sh);
               end
            end
            default: state <= ST_GAP;
         endcase
      end
   end
endmodule

// File: tb/tb_swd_frame_sequencer.sv
// tb_swd_frame_sequencer: directed vectors and multi-cycle sequences for swd_frame_sequencer
module tb_swd_frame_sequencer;
   logic sck = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   always #5 sck = ~sck;
   swd_frame_sequencer_if bus ();
   swd_frame_sequencer #(.IDLE_GAP(1), .ABORT_ON_NACK(1'b1)) dut (
      .sck  (sck),
      .rst_n(rst_n),
      .bus  (bus)
   );
   typedef struct {
      logic        apndp;
      logic        rnw;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [2:0]  ack;
      logic [31:0] rdata;
      logic        rpar;
      logic [7:0]  req;
      logic [31:0] e_rdata;
      logic        e_perr;
      logic        e_abort;
   } vec_t;
   vec_t tv[6];
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask
   task automatic wait_ready();
      for (int n = 0; n < 100 && bus.cmd_ready !== 1'b1; n++) begin
         @(posedge sck);
         #1;
      end
      chk("ready_wait", bus.cmd_ready, 1'b1);
   endtask
   task automatic run_vec(input vec_t v);
      logic [47:0] mv;
      logic [47:0] seen;
      int          ve;
      logic        fe1;
      wait_ready();
      bus.cmd_valid = 1'b1;
      bus.cmd_apndp = v.apndp;
      bus.cmd_rnw   = v.rnw;
      bus.cmd_addr  = v.addr;
      bus.cmd_wdata = v.wdata;
      @(posedge sck);
      #1;
      bus.cmd_valid = 1'b0;
      bus.cmd_apndp = ~v.apndp;
      bus.cmd_rnw   = ~v.rnw;
      bus.cmd_addr  = ~v.addr;
      bus.cmd_wdata = ~v.wdata;
      chk("rdy_after_accept", bus.cmd_ready, 1'b0);
      mv = '0;
      mv[13:11] = v.ack;
      if (v.rnw) begin
         mv[45:14] = v.rdata;
         mv[46]    = v.rpar;
      end else begin
         mv[46:14] = {1'b1, 32'h5A5A_5A5A};
      end
      seen = '0;
      ve   = -1;
      fe1  = 1'b0;
      for (int e = 1; e <= 60 && ve < 0; e++) begin
         bus.miso = (e >= 2 && e <= 49) ? mv[e-2] : 1'b0;
         @(posedge sck);
         #1;
         if (e == 1) fe1 = bus.fe_rst_n;
         if (e == 20) chk("fe_rnw", bus.fe_rnw, v.rnw);
         if (e <= 48 && bus.fe_rst_n) seen[e-1] = bus.mosi;
         if (bus.rsp_valid) ve = e;
      end
      bus.miso = 1'b0;
      chk("fe_arm_E1", fe1, 1'b1);
      chk("valid_edge", ve, v.e_abort ? 15 : 49);
      chk("rsp_ack", bus.rsp_ack, v.ack);
      chk("rsp_rdata", bus.rsp_rdata, v.e_rdata);
      chk("rsp_par_err", bus.rsp_par_err, v.e_perr);
      chk("rsp_aborted", bus.rsp_aborted, v.e_abort);
      chk("fe_low_end", bus.fe_rst_n, 1'b0);
      chk("mosi_low_end", bus.mosi, 1'b0);
      chk("pad_bits", seen[1:0], 2'b00);
      chk("req_byte", seen[9:2], v.req);
      if (!v.e_abort && !v.rnw) begin
         chk("turn_bits", seen[14:10], 5'b0);
         chk("wdata_bits", seen[46:15], v.wdata);
         chk("wpar_bit", seen[47], ^v.wdata);
      end
      if (!v.e_abort && v.rnw) chk("read_zero_bits", seen[47:10], 38'b0);
      @(posedge sck);
      #1;
      chk("valid_pulse", bus.rsp_valid, 1'b0);
      chk("ack_hold", bus.rsp_ack, v.ack);
   endtask
   initial begin
      int   e, acc, acc2_e, v1_e, rdy_hi, r;
      logic rdy, vseen;
      tv[0] = '{1'b0, 1'b0, 2'b01, 32'hCAFE_BABE, 3'b001, 32'h0, 1'b0, 8'hA9, 32'h0, 1'b0, 1'b0};
      tv[1] = '{1'b1, 1'b1, 2'b11, 32'h0, 3'b001, 32'h1234_5678, 1'b1, 8'h9F, 32'h1234_5678, 1'b0, 1'b0};
      tv[2] = '{1'b1, 1'b1, 2'b11, 32'h0, 3'b001, 32'h1234_5678, 1'b0, 8'h9F, 32'h1234_5678, 1'b1, 1'b0};
      tv[3] = '{1'b0, 1'b0, 2'b01, 32'hCAFE_BABE, 3'b010, 32'h0, 1'b0, 8'hA9, 32'h0, 1'b0, 1'b1};
      tv[4] = '{1'b0, 1'b1, 2'b00, 32'h0, 3'b100, 32'hFFFF_FFFF, 1'b1, 8'hA5, 32'h0, 1'b0, 1'b1};
      tv[5] = '{1'b1, 1'b0, 2'b10, 32'h0000_0001, 3'b001, 32'h0, 1'b0, 8'h93, 32'h0, 1'b0, 1'b0};
      bus.cmd_valid = 1'b0;
      bus.cmd_apndp = 1'b0;
      bus.cmd_rnw   = 1'b0;
      bus.cmd_addr  = 2'b00;
      bus.cmd_wdata = '0;
      bus.miso      = 1'b0;
      repeat (3) @(posedge sck);
      #1;
      chk("rst_cmd_ready", bus.cmd_ready, 1'b0);
      chk("rst_fe_rst_n", bus.fe_rst_n, 1'b0);
      chk("rst_mosi", bus.mosi, 1'b0);
      chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
      chk("rst_rsp_ack", bus.rsp_ack, 3'b000);
      chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
      #3 rst_n = 1'b1;
      for (int i = 0; i < 6; i++) run_vec(tv[i]);
      // back-to-back writes with cmd_valid held high
      wait_ready();
      @(negedge sck);
      bus.cmd_valid = 1'b1;
      bus.cmd_apndp = 1'b0;
      bus.cmd_rnw   = 1'b0;
      bus.cmd_addr  = 2'b01;
      bus.cmd_wdata = 32'h1111_2222;
      e = 0; acc = 0; acc2_e = -1; v1_e = -1; rdy_hi = 0;
      for (int n = 0; n < 200 && acc < 2; n++) begin
         bus.miso = (acc > 0 && e == 12);
         rdy = bus.cmd_ready;
         @(posedge sck);
         #1;
         e++;
         if (acc == 1 && bus.rsp_valid) v1_e = e;
         if (rdy) begin
            acc++;
            if (acc == 2) acc2_e = e;
            e = 0;
         end else if (acc == 1 && bus.cmd_ready && e < 50) rdy_hi++;
      end
      bus.cmd_valid = 1'b0;
      chk("b2b_first_valid", v1_e, 49);
      chk("b2b_second_accept", acc2_e, 51);
      chk("b2b_ready_low", rdy_hi, 0);
      vseen = 1'b0;
      for (int n = 0; n < 60 && !vseen; n++) begin
         bus.miso = (e == 12);
         @(posedge sck);
         #1;
         e++;
         vseen = bus.rsp_valid;
      end
      bus.miso = 1'b0;
      chk("b2b_second_valid", e, 49);
      chk("b2b_second_ack", bus.rsp_ack, 3'b001);
      chk("b2b_second_abort", bus.rsp_aborted, 1'b0);
      // asynchronous reset while bit 20 is on mosi
      wait_ready();
      bus.cmd_valid = 1'b1;
      bus.cmd_apndp = 1'b0;
      bus.cmd_rnw   = 1'b0;
      bus.cmd_addr  = 2'b01;
      bus.cmd_wdata = 32'hFFFF_FFFF;
      @(posedge sck);
      #1;
      bus.cmd_valid = 1'b0;
      vseen = 1'b0;
      for (int k = 1; k <= 21; k++) begin
         bus.miso = (k == 13);
         @(posedge sck);
         #1;
         vseen |= bus.rsp_valid;
      end
      bus.miso = 1'b0;
      chk("mid_fe_high", bus.fe_rst_n, 1'b1);
      chk("mid_mosi_bit20", bus.mosi, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_fe_low", bus.fe_rst_n, 1'b0);
      chk("arst_mosi_low", bus.mosi, 1'b0);
      chk("arst_fe_rnw", bus.fe_rnw, 1'b0);
      chk("arst_ready", bus.cmd_ready, 1'b0);
      #15 rst_n = 1'b1;
      r = 0;
      for (int n = 0; n < 20 && bus.cmd_ready !== 1'b1; n++) begin
         @(posedge sck);
         #1;
         r++;
         vseen |= bus.rsp_valid;
      end
      chk("arst_gap_cycles", r, 1);
      chk("arst_no_valid", vseen, 1'b0);
      run_vec(tv[0]);
      run_vec(tv[1]);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
